// File: rtl/keypad_entry_ctrl_if.sv
// Keypad entry bus: raw key inputs from the keypad controller and the
// live/committed entry outputs toward display and clock-setting logic.
interface keypad_entry_ctrl_if;
  logic [3:0]  key_value;
  logic        key_valid;
  logic [15:0] entry_value;
  logic [2:0]  entry_count;
  logic [15:0] committed_value;
  logic        commit_p;
  logic        abort_p;
  logic        busy;

  modport master (
    output key_value, key_valid,
    input  entry_value, entry_count, committed_value, commit_p, abort_p, busy
  );

  modport slave (
    input  key_value, key_valid,
    output entry_value, entry_count, committed_value, commit_p, abort_p, busy
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Turns keypad press events into a 4-digit BCD entry with backspace, clear and commit.
// Optional idle-abort timer enabled by defining KEYPAD_ENTRY_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no entry in progress, waiting for first digit
//   ENTRY | 1..4 digits collected, editing
//   DONE  | single cycle after ENTER, commit_p asserted
module keypad_entry_ctrl #(
  parameter logic [3:0] ENTER_KEY = 4'hC,
  parameter logic [3:0] BACK_KEY  = 4'hA,
  parameter logic [3:0] CLEAR_KEY = 4'hB
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 500_000_000
`endif
) (
  input  logic                clk,
  input  logic                reset_p,
  keypad_entry_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

  state_t      state, state_nxt;
  logic        key_valid_d;
  logic        key_event;
  logic        is_digit;
  logic [15:0] entry_value, entry_value_nxt;
  logic [2:0]  entry_count, entry_count_nxt;
  logic [15:0] committed_value, committed_value_nxt;
  logic        commit_q, abort_q, abort_nxt, busy_q;
  logic        tmr_hit;

  assign key_event = bus.key_valid & ~key_valid_d;
  assign is_digit  = (bus.key_value <= 4'd9);

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  localparam logic [28:0] TMR_TC = 29'(TIMEOUT_CYCLES - 1);
  logic [28:0] tmr, tmr_nxt;

  assign tmr_hit = (tmr == TMR_TC);

  // Any key event while editing restarts the idle window.
  always_comb begin
    tmr_nxt = '0;
    if (state == ENTRY && state_nxt == ENTRY && !key_event)
      tmr_nxt = tmr + 29'd1;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) tmr <= '0;
    else         tmr <= tmr_nxt;
  end
`else
  assign tmr_hit = 1'b0;
`endif

  always_comb begin
    state_nxt           = state;
    entry_value_nxt     = entry_value;
    entry_count_nxt     = entry_count;
    committed_value_nxt = committed_value;
    abort_nxt           = 1'b0;
    case (state)
      IDLE: begin
        if (key_event && is_digit) begin
          entry_value_nxt = {12'h000, bus.key_value};
          entry_count_nxt = 3'd1;
          state_nxt       = ENTRY;
        end
      end
      ENTRY: begin
        if (key_event) begin
          if (is_digit) begin
            if (entry_count < 3'd4) begin
              entry_value_nxt = {entry_value[11:0], bus.key_value};
              entry_count_nxt = entry_count + 3'd1;
            end
          end else if (bus.key_value == ENTER_KEY) begin
            committed_value_nxt = entry_value;
            state_nxt           = DONE;
          end else if (bus.key_value == BACK_KEY) begin
            entry_value_nxt = entry_value >> 4;
            entry_count_nxt = entry_count - 3'd1;
            if (entry_count == 3'd1) state_nxt = IDLE;
          end else if (bus.key_value == CLEAR_KEY) begin
            entry_value_nxt = '0;
            entry_count_nxt = '0;
            abort_nxt       = 1'b1;
            state_nxt       = IDLE;
          end
        end else if (tmr_hit) begin
          entry_value_nxt = '0;
          entry_count_nxt = '0;
          abort_nxt       = 1'b1;
          state_nxt       = IDLE;
        end
      end
      DONE: begin
        entry_value_nxt = '0;
        entry_count_nxt = '0;
        state_nxt       = IDLE;
      end
      default: begin
        entry_value_nxt = '0;
        entry_count_nxt = '0;
        state_nxt       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state           <= IDLE;
      key_valid_d     <= 1'b0;
      entry_value     <= '0;
      entry_count     <= '0;
      committed_value <= '0;
      commit_q        <= 1'b0;
      abort_q         <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state           <= state_nxt;
      key_valid_d     <= bus.key_valid;
      entry_value     <= entry_value_nxt;
      entry_count     <= entry_count_nxt;
      committed_value <= committed_value_nxt;
      commit_q        <= (state_nxt == DONE);
      abort_q         <= abort_nxt;
      busy_q          <= (state_nxt != IDLE);
    end
  end

  assign bus.entry_value     = entry_value;
  assign bus.entry_count     = entry_count;
  assign bus.committed_value = committed_value;
  assign bus.commit_p        = commit_q;
  assign bus.abort_p         = abort_q;
  assign bus.busy            = busy_q;

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Sequences raw keypad events into a 4-digit BCD entry for the time/alarm setting path.
- Sits between keypad_cntr_FSM (key_value/key_valid) and fnd_cntr/clock-setting logic.
- Detects key presses internally and runs an entry FSM with digit shift-in, backspace, clear and enter.
- Publishes a live entry value for display and a committed value with a one-cycle commit strobe.

Parameters:
ENTER_KEY, 4'hC, key code that commits the entry
BACK_KEY, 4'hA, key code that deletes the last digit
CLEAR_KEY, 4'hB, key code that aborts the entry
TIMEOUT_CYCLES, 500_000_000, idle-abort time in clk cycles (used only with the optional feature)

Ports:
clk  input  1  system clock
reset_p  input  1  asynchronous, active-high reset
key_value  input  4  key code from the keypad controller; valid while key_valid=1
key_valid  input  1  high while a key is held
entry_value  output  16  live BCD entry, {d3,d2,d1,d0}, newest digit in [3:0]
entry_count  output  3  number of digits entered, 0..4
committed_value  output  16  last committed BCD value
commit_p  output  1  one-cycle pulse when committed_value updates
abort_p  output  1  one-cycle pulse when an entry is aborted
busy  output  1  high when state != IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0, including entry_value, entry_count, committed_value, commit_p, abort_p and busy. The internal key_valid delay register and timeout counter are also cleared. An asserted reset_p mid-entry discards everything immediately.
- Key event:
  - event = key_valid & ~key_valid_d, where key_valid_d is key_valid registered on clk.
  - key_value is sampled in the event cycle.
  - Exactly one event per press, regardless of hold length.
  - Register updates take effect at the clock edge ending the event cycle, so latency is 1 cycle.
- Key classes:
  - digit: 0-9
  - ENTER_KEY, BACK_KEY, CLEAR_KEY
  - all other codes (D, E, F): ignored in every state.
- States: IDLE, ENTRY, DONE.
- IDLE:
  - digit d: entry_value<={12'h000,d}, entry_count<=1, go to ENTRY.
  - ENTER, BACK, CLEAR: ignored.
- ENTRY, digit d:
  - If entry_count<4: entry_value<={entry_value[11:0],d}, entry_count+1.
  - If entry_count==4: ignored; no change and no wrap.
- ENTRY, BACK:
  - entry_value<=entry_value>>4, entry_count-1.
  - If the result count is 0, go to IDLE.
- ENTRY, CLEAR: entry_value<=0, entry_count<=0, abort_p=1 for the following cycle, go to IDLE.
- ENTRY, ENTER: committed_value<=entry_value (right-aligned, leading zeros), go to DONE.
- DONE (exactly 1 cycle):
  - commit_p=1.
  - entry_value and entry_count clear at the exit edge; go to IDLE.
  - Events in DONE are ignored.
- Pulse timing: commit_p and abort_p are registered and never high together. Each is high for exactly one cycle.
- busy=1 in ENTRY and DONE.
- committed_value changes only on commit. Clear and timeout leave it unchanged.

Optional Feature:
Macro KEYPAD_ENTRY_TIMEOUT_EN.
- Defined:
  - A 29-bit counter runs in ENTRY and resets to 0 on every accepted event and on entry to ENTRY.
  - When the count reaches TIMEOUT_CYCLES-1 with no event in that cycle: entry_value<=0, entry_count<=0, abort_p pulse, go to IDLE.
  - If an event and the terminal count occur in the same cycle, the event wins and the counter resets.
  - The counter is held at 0 outside ENTRY.
- Not defined: no counter is synthesized. ENTRY persists indefinitely, and abort_p comes only from CLEAR.

Test Plan:
1. Press 1,2,3,4 then C (each press 10 cycles high, 10 low):
   - entry_value steps 0x0001, 0x0012, 0x0123, 0x1234.
   - commit_p is high for 1 cycle and committed_value=0x1234 on the same cycle.
   - busy=0 and entry_value=0 on the next cycle.
2. Press 1,2,3,4,5:
   - entry_value=0x1234, entry_count=4; the 5 is ignored.
   - Then press C: committed_value=0x1234.
3. Press 7,8,A:
   - entry_value=0x0007, entry_count=1.
   - Press A again: state=IDLE, entry_value=0, busy=0, no abort_p.
4. Commit 0x0042, then press 9,B:
   - abort_p is high for 1 cycle and entry_value=0.
   - committed_value stays 0x0042, with no commit_p.
5. Hold key_valid high 1000 cycles with key_value=3:
   - Exactly one digit is taken (entry_value=0x0003).
   - Press F and C in IDLE beforehand: both have no effect.
6. TIMEOUT_CYCLES=100 with macro defined: press 6 and release.
   - abort_p fires 100 cycles after the event edge; committed_value is unchanged.
   - Without the macro there is no abort after 10000 cycles.
   - Assert reset_p mid-entry: all outputs are 0 asynchronously.
